phase_compressor_pipe: RTL and testbench

PHASE_COMPRESSOR_PIPE -- requirements
Module: phase_compressor_pipe

---
 rtl/phase_pkg.sv | 15 +
 rtl/phase_fold.sv | 28 ++
 rtl/phase_compressor_pipe.sv | 117 +++++++++++
 tb/tb_phase_compressor_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared widths and the width-consistency rule for the phase compressor.
package phase_pkg;

    localparam int PHASE_W_DEF = 16;
    localparam int QUA_W_DEF   = 3;
    localparam int REA_W_DEF   = 6;
    localparam int COR_W_DEF   = 7;
    localparam int TAG_W_DEF   = 1;

    function automatic bit widths_ok(input int phase_w, input int qua_w,
                                     input int rea_w, input int cor_w);
        return (phase_w == qua_w + rea_w + cor_w) && (qua_w >= 1);
    endfunction

endpackage

// File: rtl/phase_fold.sv
// Combinational octant fold: mirrors the lower field when the half-octant bit is set,
// then splits the word into octant, coarse and fine indices.
module phase_fold
    import phase_pkg::*;
#(
    parameter int QUA_W = QUA_W_DEF,
    parameter int REA_W = REA_W_DEF,
    parameter int COR_W = COR_W_DEF
) (
    input  logic [QUA_W+REA_W+COR_W-1:0] phase,
    output logic [QUA_W-1:0]             qua,
    output logic [REA_W-1:0]             rea,
    output logic [COR_W-1:0]             cor,
    output logic                         fold
);

    localparam int PHASE_W = QUA_W + REA_W + COR_W;
    localparam int L       = REA_W + COR_W;

    logic [L-1:0] idx;

    assign fold = phase[L];
    assign idx  = fold ? ~phase[L-1:0] : phase[L-1:0];
    assign qua  = phase[PHASE_W-1:L];
    assign rea  = idx[L-1:COR_W];
    assign cor  = idx[COR_W-1:0];

endmodule

// File: rtl/phase_compressor_pipe.sv
// Two-stage phase compressor: S1 captures/accumulates the phase, S2 folds and splits it.
// Both stages advance together whenever the output register is empty or being taken.
module phase_compressor_pipe
    import phase_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int QUA_W   = QUA_W_DEF,
    parameter int REA_W   = REA_W_DEF,
    parameter int COR_W   = COR_W_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic               acc_clear,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [QUA_W-1:0]   index_qua,
    output logic [REA_W-1:0]   index_rea,
    output logic [COR_W-1:0]   index_cor,
    output logic               fold,
    output logic [TAG_W-1:0]   tag_out,
    output logic [PHASE_W-1:0] acc_phase
);

    if (!widths_ok(PHASE_W, QUA_W, REA_W, COR_W)) begin : g_bad_widths
        $fatal(1, "phase_compressor_pipe: PHASE_W must equal QUA_W+REA_W+COR_W with QUA_W >= 1");
    end

    logic               advance;
    logic               accept;
    logic [PHASE_W-1:0] acc_base;
    logic [PHASE_W-1:0] p_next;

    logic               s1_valid;
    logic [PHASE_W-1:0] s1_phase;
    logic [TAG_W-1:0]   s1_tag;

    logic [QUA_W-1:0]   f_qua;
    logic [REA_W-1:0]   f_rea;
    logic [COR_W-1:0]   f_cor;
    logic               f_fold;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    // Clear happens before the add, so a cleared frequency sample starts from zero.
    always_comb begin
        acc_base = acc_clear ? '0 : acc_phase;
        p_next   = mode ? (acc_base + phase_in) : phase_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_phase <= '0;
        end else if (accept) begin
            if (mode) begin
                acc_phase <= p_next;
            end else if (acc_clear) begin
                acc_phase <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_phase <= '0;
            s1_tag   <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_phase <= p_next;
                s1_tag   <= tag_in;
            end
        end
    end

    phase_fold #(
        .QUA_W (QUA_W),
        .REA_W (REA_W),
        .COR_W (COR_W)
    ) u_fold (
        .phase (s1_phase),
        .qua   (f_qua),
        .rea   (f_rea),
        .cor   (f_cor),
        .fold  (f_fold)
    );

    // Output fields only load on a real sample so bubbles leave the last values visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            index_qua <= '0;
            index_rea <= '0;
            index_cor <= '0;
            fold      <= 1'b0;
            tag_out   <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                index_qua <= f_qua;
                index_rea <= f_rea;
                index_cor <= f_cor;
                fold      <= f_fold;
                tag_out   <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_phase_compressor_pipe.sv
// Directed bench for phase_compressor_pipe with hand-computed expectations.
module tb_phase_compressor_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic        acc_clear;
    logic [15:0] phase_in;
    logic [0:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  index_qua;
    logic [5:0]  index_rea;
    logic [6:0]  index_cor;
    logic        fold;
    logic [0:0]  tag_out;
    logic [15:0] acc_phase;

    int passed = 0;
    int total  = 0;

    phase_compressor_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .acc_clear (acc_clear),
        .phase_in  (phase_in),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .index_qua (index_qua),
        .index_rea (index_rea),
        .index_cor (index_cor),
        .fold      (fold),
        .tag_out   (tag_out),
        .acc_phase (acc_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic clr, input logic [15:0] ph, input logic t);
        in_valid  = v;
        mode      = m;
        acc_clear = clr;
        phase_in  = ph;
        tag_in    = t;
    endtask

    initial begin
        logic [4:0]  tagv;
        logic [5:0]  snap_rea;
        logic        was_stalled;
        logic        took;
        int          i;
        int          n;

        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        cycle();
        cycle();
        #2 reset = 1'b0;
        cycle();

        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_acc", {16'd0, acc_phase}, 32'd0);
        chk("rst_fields", {index_qua, index_rea, index_cor, fold, tag_out}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Direct phase 0x1234: no fold
        drive(1'b1, 1'b0, 1'b0, 16'h1234, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("d1234_lat1_valid", {31'd0, out_valid}, 32'd0);
        cycle();
        chk("d1234_valid", {31'd0, out_valid}, 32'd1);
        chk("d1234_fields", {index_qua, index_rea, index_cor, fold, tag_out},
            {3'd0, 6'h24, 7'h34, 1'b0, 1'b1});
        cycle();
        chk("bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_hold", {index_qua, index_rea, index_cor, fold}, {3'd0, 6'h24, 7'h34, 1'b0});

        // Direct phase 0x3000: mirrored half-octant
        drive(1'b1, 1'b0, 1'b0, 16'h3000, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        cycle();
        chk("d3000_fields", {out_valid, index_qua, index_rea, index_cor, fold},
            {1'b1, 3'd1, 6'h1F, 7'h7F, 1'b1});

        // Accumulator: clear then four steps of 0x4000 with wrap
        drive(1'b1, 1'b1, 1'b1, 16'h4000, 1'b0);
        cycle();
        chk("acc_step1", {16'd0, acc_phase}, 32'h4000);
        drive(1'b1, 1'b1, 1'b0, 16'h4000, 1'b0);
        cycle();
        chk("acc_step2", {16'd0, acc_phase}, 32'h8000);
        chk("acc_out1", {out_valid, index_qua, index_rea, index_cor, fold}, {1'b1, 3'd2, 6'd0, 7'd0, 1'b0});
        cycle();
        chk("acc_step3", {16'd0, acc_phase}, 32'hC000);
        chk("acc_out2", {out_valid, index_qua}, {1'b1, 3'd4});
        cycle();
        chk("acc_wrap", {16'd0, acc_phase}, 32'h0000);
        chk("acc_out3", {out_valid, index_qua}, {1'b1, 3'd6});
        drive(1'b0, 1'b1, 1'b0, 16'h4000, 1'b0);
        cycle();
        chk("acc_out4", {out_valid, index_qua, index_rea, index_cor, fold}, {1'b1, 3'd0, 6'd0, 7'd0, 1'b0});
        cycle();
        chk("acc_idle_hold", {16'd0, acc_phase}, 32'h0000);

        // Clear-then-operate from a non-zero accumulator
        drive(1'b1, 1'b1, 1'b0, 16'h5000, 1'b0);
        cycle();
        chk("acc_5000", {16'd0, acc_phase}, 32'h5000);
        drive(1'b1, 1'b1, 1'b1, 16'h0100, 1'b1);
        cycle();
        chk("clr_acc", {16'd0, acc_phase}, 32'h0100);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        cycle();
        chk("clr_out", {out_valid, index_qua, index_rea, index_cor, fold, tag_out},
            {1'b1, 3'd0, 6'h02, 7'h00, 1'b0, 1'b1});
        drive(1'b1, 1'b0, 1'b1, 16'h0777, 1'b0);
        cycle();
        chk("clr_mode0_acc", {16'd0, acc_phase}, 32'h0000);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        cycle();
        cycle();

        // Five tagged samples with a 3-cycle downstream stall
        tagv = 5'b01101;
        i = 0;
        n = 0;
        was_stalled = 1'b0;
        snap_rea = '0;
        drive(1'b1, 1'b0, 1'b0, 16'h0100, tagv[0]);
        for (int c = 0; c < 30 && n < 5; c++) begin
            out_ready = (c >= 3 && c < 6) ? 1'b0 : 1'b1;
            #1;
            if (was_stalled) begin
                chk("stall_hold", {out_valid, index_rea}, {1'b1, snap_rea});
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                snap_rea = index_rea;
            end
            if (out_valid && out_ready) begin
                chk("stream_rea", {26'd0, index_rea}, 32'(2 * (n + 1)));
                chk("stream_tag", {31'd0, tag_out}, {31'd0, tagv[n]});
                n++;
            end
            was_stalled = out_valid && !out_ready;
            took = in_valid && in_ready;
            cycle();
            if (took) begin
                i++;
                if (i < 5) drive(1'b1, 1'b0, 1'b0, 16'((i + 1) * 256), tagv[i]);
                else drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
            end
        end
        chk("stream_count", n, 32'd5);
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        cycle();

        // Asynchronous reset with two samples in flight
        drive(1'b1, 1'b1, 1'b0, 16'h1000, 1'b1);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 16'h1000, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_acc", {16'd0, acc_phase}, 32'd0);
        chk("arst_fields", {index_qua, index_rea, index_cor, fold, tag_out}, 32'd0);
        cycle();
        #2 reset = 1'b0;
        cycle();
        chk("post_rst_idle1", {31'd0, out_valid}, 32'd0);
        cycle();
        chk("post_rst_idle2", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 16'h0200, 1'b1);
        cycle();
        chk("post_rst_acc", {16'd0, acc_phase}, 32'h0200);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        cycle();
        chk("post_rst_out", {out_valid, index_qua, index_rea, index_cor, fold, tag_out},
            {1'b1, 3'd0, 6'h04, 7'h00, 1'b0, 1'b1});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, want finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
